mem_panel_ctrl: RTL and testbench

Front-panel controller that sequences the on-board data memory from switches and push-buttons. Raw buttons are synchronized, debounced and turned into one-cycle commands: load address, write, or step to the next address. Every command ends with an automatic read-back of the current address, so the display always shows live memory contents. Sits between the board I/O (SW, buttons, LEDs) and the single-port synchronous memory.

---
 rtl/mem_panel_ctrl.sv | 114 +++++++++++
 tb/tb_mem_panel_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_panel_ctrl.sv
// Front-panel memory controller: debounced buttons drive address load, write and
// next-address commands, each followed by an automatic read-back for the display.
module mem_panel_ctrl #(
   parameter int unsigned ADDR_W          = 10,
   parameter int unsigned DATA_W          = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       SW,
   input  logic              BTN_addr,
   input  logic              BTN_write,
   input  logic              BTN_next,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       out,
   output logic [ADDR_W-1:0] addr_out,
   output logic              busy
);

   localparam int unsigned NBTN     = 3;
   localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned BTN_ADDR = 0;
   localparam int unsigned BTN_WR   = 1;
   localparam int unsigned BTN_NEXT = 2;

   typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;

   logic [NBTN-1:0]   btn_raw;
   logic [NBTN-1:0]   sync1;
   logic [NBTN-1:0]   sync2;
   logic [NBTN-1:0]   level;
   logic [NBTN-1:0]   pulse;
   logic [CNT_W-1:0]  cnt [NBTN];

   state_t            state;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;

   assign btn_raw   = {BTN_next, BTN_write, BTN_addr};
   assign mem_addr  = addr_reg;
   assign addr_out  = addr_reg;
   assign mem_wdata = wdata_reg;

   // Synchronize, debounce and edge-detect; pulse rises together with the accepted level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         level <= '0;
         pulse <= '0;
         for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         for (int i = 0; i < NBTN; i++) begin
            if (sync2[i] == level[i]) begin
               cnt[i]   <= '0;
               pulse[i] <= 1'b0;
            end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               cnt[i]   <= '0;
               level[i] <= sync2[i];
               pulse[i] <= sync2[i];
            end else begin
               cnt[i]   <= cnt[i] + CNT_W'(1);
               pulse[i] <= 1'b0;
            end
         end
      end
   end

   // Command sequencer; pulses outside IDLE are ignored rather than queued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_reg  <= '0;
         wdata_reg <= '0;
         out       <= '0;
         mem_we    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (pulse[BTN_ADDR]) begin
                  addr_reg <= SW[ADDR_W-1:0];
                  state    <= RD;
                  busy     <= 1'b1;
               end else if (pulse[BTN_WR]) begin
                  wdata_reg <= DATA_W'(SW);
                  mem_we    <= 1'b1;
                  state     <= WR;
                  busy      <= 1'b1;
               end else if (pulse[BTN_NEXT]) begin
                  addr_reg <= addr_reg + ADDR_W'(1);
                  state    <= RD;
                  busy     <= 1'b1;
               end
            end
            WR:  state <= RD;
            RD:  state <= CAP;
            CAP: begin
               out   <= 16'(mem_rdata);
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_panel_ctrl.sv
// Directed bench for mem_panel_ctrl with a behavioural 1024x16 single-cycle-read memory.
module tb_mem_panel_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] sw;
   logic [2:0]  btn;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic [15:0] mem_rdata;
   logic [15:0] out;
   logic [9:0]  addr_out;
   logic        busy;

   logic [15:0] mem [1024];
   int          checks = 0;
   int          errors = 0;
   int          we_cnt = 0;
   int          we_base;
   logic [9:0]  we_last_addr;
   bit          seen;

   always #5 clk = ~clk;

   mem_panel_ctrl #(.ADDR_W(10), .DATA_W(16), .DEBOUNCE_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .SW        (sw),
      .BTN_addr  (btn[0]),
      .BTN_write (btn[1]),
      .BTN_next  (btn[2]),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .out       (out),
      .addr_out  (addr_out),
      .busy      (busy)
   );

   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         mem[mem_addr] <= mem_wdata;
         we_cnt        <= we_cnt + 1;
         we_last_addr  <= mem_addr;
      end
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold the selected buttons for 'hold' cycles, release, then let everything settle.
   task automatic press(input logic [2:0] mask, input int hold);
      btn = mask;
      cycles(hold);
      btn = 3'b000;
      cycles(16);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      rst_n = 1'b0;
      sw    = 16'h0000;
      btn   = 3'b000;
      cycles(4);
      check("rst_out",  32'(out), 32'h0);
      check("rst_addr", 32'(addr_out), 32'h0);
      check("rst_we",   32'(mem_we), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      cycles(10);
      check("rel_out",  32'(out), 32'h0);
      check("rel_addr", 32'(addr_out), 32'h0);
      check("rel_busy", 32'(busy), 32'h0);
      check("rel_we",   32'(we_cnt), 32'd0);

      // Load address 5 then write 0x3039
      sw = 16'd5;
      press(3'b001, 10);
      check("load5_addr", 32'(addr_out), 32'd5);
      sw = 16'h3039;
      we_base = we_cnt;
      press(3'b010, 10);
      check("wr5_we_cnt", 32'(we_cnt - we_base), 32'd1);
      check("wr5_we_addr", 32'(we_last_addr), 32'd5);
      check("wr5_out", 32'(out), 32'h3039);
      check("wr5_busy", 32'(busy), 32'h0);

      // Second location, then reload 5
      sw = 16'd1001;
      press(3'b001, 10);
      check("load1001_addr", 32'(addr_out), 32'd1001);
      sw = 16'hABCD;
      press(3'b010, 10);
      check("wr1001_out", 32'(out), 32'hABCD);
      sw = 16'd5;
      press(3'b001, 10);
      check("reload5_out", 32'(out), 32'h3039);

      // Next with wrap
      sw = 16'd1023;
      press(3'b001, 10);
      sw = 16'h1111;
      press(3'b010, 10);
      check("wr1023_out", 32'(out), 32'h1111);
      press(3'b100, 10);
      check("wrap_addr", 32'(addr_out), 32'd0);
      check("wrap_out",  32'(out), 32'h0);
      press(3'b100, 10);
      check("next1_addr", 32'(addr_out), 32'd1);

      // Debounce: short bounce ignored, long hold gives one write
      we_base = we_cnt;
      sw = 16'h5A5A;
      press(3'b010, 3);
      check("bounce_we", 32'(we_cnt - we_base), 32'd0);
      press(3'b010, 20);
      check("hold_we", 32'(we_cnt - we_base), 32'd1);
      check("hold_out", 32'(out), 32'h5A5A);

      // Simultaneous addr and next: only the load happens
      sw = 16'd7;
      press(3'b101, 10);
      check("conflict_addr", 32'(addr_out), 32'd7);

      // Next landing while the write sequence is busy is dropped
      sw = 16'h0F0F;
      we_base = we_cnt;
      btn = 3'b010;
      cycles(2);
      btn = 3'b110;
      cycles(10);
      btn = 3'b000;
      cycles(16);
      check("busy_drop_addr", 32'(addr_out), 32'd7);
      check("busy_drop_we", 32'(we_cnt - we_base), 32'd1);
      check("busy_drop_out", 32'(out), 32'h0F0F);

      // Reset during WR
      sw = 16'hBEEF;
      btn = 3'b010;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (mem_we === 1'b1) seen = 1'b1;
      end
      check("wr_seen", 32'(seen), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstwr_we",   32'(mem_we), 32'h0);
      check("rstwr_busy", 32'(busy), 32'h0);
      check("rstwr_addr", 32'(addr_out), 32'h0);
      check("rstwr_out",  32'(out), 32'h0);
      btn = 3'b000;
      cycles(3);
      rst_n = 1'b1;
      cycles(12);
      check("post_rst_busy", 32'(busy), 32'h0);
      check("post_rst_addr", 32'(addr_out), 32'h0);
      sw = 16'd3;
      press(3'b001, 10);
      check("post_rst_load", 32'(addr_out), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
